ripple_carry_adder_nbit: RTL and testbench



---
 rtl/ripple_carry_adder_nbit.sv | 75 +++++++
 tb/tb_ripple_carry_adder_nbit.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/ripple_carry_adder_nbit.sv
// N-bit unsigned ripple-carry adder with registered sum/carry (one clock latency).
// Optional RCA_OVF_EN adds a registered two's-complement overflow flag (ovf).

module rca_full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module ripple_carry_adder_nbit #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
`ifdef RCA_OVF_EN
    output logic         ovf,
`endif
    output logic [N-1:0] sum,
    output logic         cout
);

    logic [N:0]   c_p0;
    logic [N-1:0] s_p0;
    logic [N-1:0] sum_p1;
    logic         cout_p1;

    assign c_p0[0] = 1'b0;

    // Stage p0: carry ripples LSB to MSB through one cell per bit
    for (genvar i = 0; i < N; i++) begin : g_cell
        rca_full_adder u_fa (
            .a  (A[i]),
            .b  (B[i]),
            .ci (c_p0[i]),
            .s  (s_p0[i]),
            .co (c_p0[i+1])
        );
    end

    // Stage p1: output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_p1  <= '0;
            cout_p1 <= 1'b0;
        end else begin
            sum_p1  <= s_p0;
            cout_p1 <= c_p0[N];
        end
    end

`ifdef RCA_OVF_EN
    logic ovf_p1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_p1 <= 1'b0;
        end else begin
            ovf_p1 <= c_p0[N] ^ c_p0[N-1];
        end
    end

    assign ovf = ovf_p1;
`endif

    assign sum  = sum_p1;
    assign cout = cout_p1;

endmodule

// File: tb/tb_ripple_carry_adder_nbit.sv
// Directed self-checking bench for ripple_carry_adder_nbit at N = 4, 1 and 8.
// Checks ovf as well when RCA_OVF_EN is defined.

module tb_ripple_carry_adder_nbit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] a4, b4, sum4;
    logic       cout4;
    logic [0:0] a1, b1, sum1;
    logic       cout1;
    logic [7:0] a8, b8, sum8;
    logic       cout8;
`ifdef RCA_OVF_EN
    logic       ovf4, ovf1, ovf8;
`endif

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    ripple_carry_adder_nbit #(.N(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .A(a4), .B(b4),
`ifdef RCA_OVF_EN
        .ovf(ovf4),
`endif
        .sum(sum4), .cout(cout4)
    );

    ripple_carry_adder_nbit #(.N(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .A(a1), .B(b1),
`ifdef RCA_OVF_EN
        .ovf(ovf1),
`endif
        .sum(sum1), .cout(cout1)
    );

    ripple_carry_adder_nbit #(.N(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .A(a8), .B(b8),
`ifdef RCA_OVF_EN
        .ovf(ovf8),
`endif
        .sum(sum8), .cout(cout8)
    );

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held for two edges with max operands applied
        rst_n = 1'b0;
        a4 = 4'd15; b4 = 4'd15;
        a1 = 1'b1;  b1 = 1'b1;
        a8 = 8'd200; b8 = 8'd100;
        tick();
        check("reset_edge1_n4", {4'd0, cout4, sum4}, 9'd0);
        tick();
        check("reset_edge2_n4", {4'd0, cout4, sum4}, 9'd0);
        check("reset_n1", {7'd0, cout1, sum1}, 9'd0);
        check("reset_n8", {cout8, sum8}, 9'd0);
`ifdef RCA_OVF_EN
        check("reset_ovf", {6'd0, ovf4, ovf1, ovf8}, 9'd0);
`endif

        // First edge out of reset: 15+15 = 30 -> sum 14, cout 1
        rst_n = 1'b1;
        tick();
        check("release_sum", {5'd0, sum4}, 9'd14);
        check("release_cout", {8'd0, cout4}, 9'd1);
        check("n1_1p1", {7'd0, cout1, sum1}, 9'b10);
        check("n8_200p100_sum", {1'b0, sum8}, 9'd44);
        check("n8_200p100_cout", {8'd0, cout8}, 9'd1);
`ifdef RCA_OVF_EN
        check("n1_ovf_eq_cout", {8'd0, ovf1}, 9'd1);
`endif

        // No carry
        a4 = 4'd7; b4 = 4'd8;
        tick();
        check("nocarry", {4'd0, cout4, sum4}, 9'd15);
`ifdef RCA_OVF_EN
        check("nocarry_ovf", {8'd0, ovf4}, 9'd0);
`endif

        // Inputs change between edges must not disturb held outputs
        a4 = 4'd1; b4 = 4'd2;
        #2;
        check("hold_between_edges", {4'd0, cout4, sum4}, 9'd15);

        // Full ripple wrap
        a4 = 4'd15; b4 = 4'd1;
        tick();
        check("wrap_sum", {5'd0, sum4}, 9'd0);
        check("wrap_cout", {8'd0, cout4}, 9'd1);

`ifdef RCA_OVF_EN
        a4 = 4'd7; b4 = 4'd1;
        tick();
        check("ovf_7p1", {3'd0, ovf4, cout4, sum4}, {3'd0, 1'b1, 1'b0, 4'd8});
        a4 = 4'd8; b4 = 4'd8;
        tick();
        check("ovf_8p8", {3'd0, ovf4, cout4, sum4}, {3'd0, 1'b1, 1'b1, 4'd0});
`endif

        // Back-to-back throughput
        a4 = 4'd3; b4 = 4'd4;
        tick();
        check("b2b_3p4", {4'd0, cout4, sum4}, {4'd0, 1'b0, 4'd7});
        a4 = 4'd9; b4 = 4'd9;
        tick();
        check("b2b_9p9", {4'd0, cout4, sum4}, {4'd0, 1'b1, 4'd2});
        a4 = 4'd0; b4 = 4'd0;
        tick();
        check("b2b_0p0", {4'd0, cout4, sum4}, 9'd0);

        // Mid-operation reset discards the pending result
        a4 = 4'd12; b4 = 4'd5;
        rst_n = 1'b0;
        tick();
        check("midreset", {4'd0, cout4, sum4}, 9'd0);
        rst_n = 1'b1;
        tick();
        check("after_midreset", {4'd0, cout4, sum4}, {4'd0, 1'b1, 4'd1});

        // Every operand pair for N = 4
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                a4 = 4'(i); b4 = 4'(j);
                tick();
                check($sformatf("exh_%0d_%0d", i, j), {4'd0, cout4, sum4}, 9'(i + j));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
